// File: rtl/dcache_pkg.sv
// Shared dcache types and geometry: address split, controller state encoding and the
// word-merge helper used by both store paths.
`timescale 1ns/1ps
package dcache_pkg;
  localparam int ADDR_W  = 32;
  localparam int INDEX_W = 5;
  localparam int LINE_W  = 256;
  localparam int WORD_W  = 32;
  localparam int OFF_W   = $clog2(LINE_W / 8);
  localparam int TAG_W   = ADDR_W - INDEX_W - OFF_W;
  localparam int SEL_W   = OFF_W - 2;
  localparam int LINES   = 2 ** INDEX_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WB     = 2'd1,
    FILL   = 2'd2,
    REFILL = 2'd3
  } state_e;

  function automatic logic [LINE_W-1:0] merge_word(input logic [LINE_W-1:0] line,
                                                   input logic [WORD_W-1:0] word,
                                                   input logic [SEL_W-1:0]  sel);
    logic [LINE_W-1:0] res;
    res = line;
    res[int'(sel) * WORD_W +: WORD_W] = word;
    return res;
  endfunction
endpackage

// File: rtl/dcache_tag_sram.sv
// Tag/valid/dirty array: combinational read, synchronous write, valid and dirty cleared
// asynchronously by reset (tags keep stale contents, masked by valid).
`timescale 1ns/1ps
module dcache_tag_sram
  import dcache_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [INDEX_W-1:0] idx_i,
  output logic [TAG_W-1:0]   tag_o,
  output logic               valid_o,
  output logic               dirty_o,
  input  logic               we_i,
  input  logic [TAG_W-1:0]   wr_tag_i,
  input  logic               wr_dirty_i
);
  logic [TAG_W-1:0] tag_q [LINES];
  logic [LINES-1:0] valid_q;
  logic [LINES-1:0] dirty_q;

  assign tag_o   = tag_q[idx_i];
  assign valid_o = valid_q[idx_i];
  assign dirty_o = dirty_q[idx_i];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (we_i) begin
      valid_q[idx_i] <= 1'b1;
      dirty_q[idx_i] <= wr_dirty_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      tag_q[idx_i] <= wr_tag_i;
    end
  end
endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back/write-allocate L1 D-cache controller: hit/miss decision for the
// MEM stage, data SRAM sequencing, and line write-back/fill towards data memory.
`timescale 1ns/1ps
module dcache_controller
  import dcache_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               cpu_req_i,
  input  logic               cpu_we_i,
  input  logic [ADDR_W-1:0]  cpu_addr_i,
  input  logic [WORD_W-1:0]  cpu_data_i,
  output logic [WORD_W-1:0]  cpu_data_o,
  output logic               cpu_stall_o,
  output logic [INDEX_W-1:0] sram_addr_o,
  output logic [LINE_W-1:0]  sram_data_o,
  output logic               sram_enable_o,
  output logic               sram_write_o,
  input  logic [LINE_W-1:0]  sram_data_i,
  output logic               mem_enable_o,
  output logic               mem_write_o,
  output logic [ADDR_W-1:0]  mem_addr_o,
  output logic [LINE_W-1:0]  mem_data_o,
  input  logic [LINE_W-1:0]  mem_data_i,
  input  logic               mem_ack_i
);
  state_e             state_q;
  logic               mem_en_q;
  logic               mem_we_q;
  logic [ADDR_W-1:0]  mem_addr_q;
  logic [LINE_W-1:0]  wb_line_q;
  logic [LINE_W-1:0]  fill_line_q;

  logic [INDEX_W-1:0] idx_s;
  logic [TAG_W-1:0]   tag_s;
  logic [OFF_W-1:0]   off_s;
  logic [SEL_W-1:0]   sel_s;
  logic [TAG_W-1:0]   rd_tag_s;
  logic               rd_valid_s;
  logic               rd_dirty_s;
  logic               hit_s;
  logic               tag_we_s;
  logic               tag_dirty_s;

  assign idx_s = cpu_addr_i[OFF_W +: INDEX_W];
  assign tag_s = cpu_addr_i[ADDR_W-1 -: TAG_W];
  assign off_s = cpu_addr_i[OFF_W-1:0];
  // Shifting the whole offset drops the byte-in-word bits, which the CPU side never uses.
  assign sel_s = SEL_W'(off_s >> 2);
  assign hit_s = cpu_req_i & rd_valid_s & (rd_tag_s == tag_s);

  dcache_tag_sram u_tag (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .idx_i      (idx_s),
    .tag_o      (rd_tag_s),
    .valid_o    (rd_valid_s),
    .dirty_o    (rd_dirty_s),
    .we_i       (tag_we_s),
    .wr_tag_i   (tag_s),
    .wr_dirty_i (tag_dirty_s)
  );

  assign sram_addr_o  = idx_s;
  assign cpu_stall_o  = ~rst_i & ((state_q != IDLE) | (cpu_req_i & ~hit_s));
  assign mem_enable_o = mem_en_q;
  assign mem_write_o  = mem_we_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_data_o   = wb_line_q;

  // Data SRAM strobes, tag updates and load data for the current state.
  always_comb begin
    sram_enable_o = 1'b0;
    sram_write_o  = 1'b0;
    sram_data_o   = merge_word(sram_data_i, cpu_data_i, sel_s);
    tag_we_s      = 1'b0;
    tag_dirty_s   = 1'b0;
    cpu_data_o    = '0;
    case (state_q)
      IDLE: begin
        sram_enable_o = cpu_req_i;
        if (hit_s && cpu_we_i) begin
          sram_write_o = 1'b1;
          tag_we_s     = 1'b1;
          tag_dirty_s  = 1'b1;
        end else if (hit_s) begin
          cpu_data_o = sram_data_i[int'(sel_s) * WORD_W +: WORD_W];
        end else begin
          sram_write_o = 1'b0;
        end
      end
      REFILL: begin
        sram_enable_o = 1'b1;
        sram_write_o  = 1'b1;
        sram_data_o   = cpu_we_i ? merge_word(fill_line_q, cpu_data_i, sel_s) : fill_line_q;
        tag_we_s      = 1'b1;
        tag_dirty_s   = cpu_we_i;
      end
      default: begin
        sram_enable_o = 1'b0;
      end
    endcase
  end

  // Miss sequencing; FILL re-raises mem_enable one cycle after a write-back ack so the
  // memory sees an idle cycle between the two requests.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      wb_line_q   <= '0;
      fill_line_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cpu_req_i && !hit_s) begin
            mem_en_q <= 1'b1;
            if (rd_valid_s && rd_dirty_s) begin
              state_q    <= WB;
              mem_we_q   <= 1'b1;
              mem_addr_q <= {rd_tag_s, idx_s, {OFF_W{1'b0}}};
              wb_line_q  <= sram_data_i;
            end else begin
              state_q    <= FILL;
              mem_we_q   <= 1'b0;
              mem_addr_q <= {tag_s, idx_s, {OFF_W{1'b0}}};
            end
          end
        end
        WB: begin
          if (mem_ack_i) begin
            state_q    <= FILL;
            mem_en_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= {tag_s, idx_s, {OFF_W{1'b0}}};
          end
        end
        FILL: begin
          if (mem_ack_i && mem_en_q) begin
            state_q     <= REFILL;
            mem_en_q    <= 1'b0;
            fill_line_q <= mem_data_i;
          end else begin
            mem_en_q <= 1'b1;
          end
        end
        REFILL: begin
          state_q <= IDLE;
        end
        default: begin
          state_q  <= IDLE;
          mem_en_q <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller with behavioural data SRAM and 3-cycle line memory.
`timescale 1ns/1ps
module tb_dcache_controller;
  import dcache_pkg::*;

  localparam int LAT = 3;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               cpu_req_i = 1'b0;
  logic               cpu_we_i = 1'b0;
  logic [ADDR_W-1:0]  cpu_addr_i = '0;
  logic [WORD_W-1:0]  cpu_data_i = '0;
  logic [WORD_W-1:0]  cpu_data_o;
  logic               cpu_stall_o;
  logic [INDEX_W-1:0] sram_addr_o;
  logic [LINE_W-1:0]  sram_data_o;
  logic               sram_enable_o;
  logic               sram_write_o;
  logic [LINE_W-1:0]  sram_data_i;
  logic               mem_enable_o;
  logic               mem_write_o;
  logic [ADDR_W-1:0]  mem_addr_o;
  logic [LINE_W-1:0]  mem_data_o;
  logic [LINE_W-1:0]  mem_data_i = '0;
  logic               mem_ack_i = 1'b0;

  int total = 0;
  int bad   = 0;

  dcache_controller dut (
    .clk_i(clk), .rst_i(rst),
    .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
    .cpu_data_i(cpu_data_i), .cpu_data_o(cpu_data_o), .cpu_stall_o(cpu_stall_o),
    .sram_addr_o(sram_addr_o), .sram_data_o(sram_data_o), .sram_enable_o(sram_enable_o),
    .sram_write_o(sram_write_o), .sram_data_i(sram_data_i),
    .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i)
  );

  always #5 clk = ~clk;

  // Data SRAM model: combinational read, write on clock edge.
  logic [LINE_W-1:0] sram_m [LINES];
  initial for (int i = 0; i < LINES; i++) sram_m[i] = '0;
  assign sram_data_i = sram_m[sram_addr_o];
  always @(posedge clk) if (sram_enable_o && sram_write_o) sram_m[sram_addr_o] <= sram_data_o;

  function automatic logic [LINE_W-1:0] gen(input logic [31:0] a);
    logic [LINE_W-1:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = a + 32'(4 * i);
    return l;
  endfunction

  // Line memory model plus traffic monitors.
  logic [LINE_W-1:0] mem_m [logic [31:0]];
  int cnt = 0, wb_cnt = 0, fill_cnt = 0, gap = 0, sram_wr_cnt = 0, mem_en_cyc = 0;
  logic gap_meas = 1'b0;
  logic [31:0] wb_addr = '0, fill_addr = '0;
  logic [LINE_W-1:0] wb_data = '0;
  always @(negedge clk) begin
    sram_wr_cnt = sram_wr_cnt + int'(sram_write_o);
    mem_en_cyc  = mem_en_cyc + int'(mem_enable_o);
    if (gap_meas) begin
      if (!mem_enable_o) gap = gap + 1;
      else gap_meas = 1'b0;
    end
    if (mem_ack_i) begin
      mem_ack_i = 1'b0;
      cnt = 0;
    end else if (mem_enable_o) begin
      cnt = cnt + 1;
      if (cnt == LAT) begin
        mem_ack_i = 1'b1;
        if (mem_write_o) begin
          mem_m[mem_addr_o] = mem_data_o;
          wb_cnt = wb_cnt + 1; wb_addr = mem_addr_o; wb_data = mem_data_o;
          gap_meas = 1'b1; gap = 0;
        end else begin
          fill_cnt = fill_cnt + 1; fill_addr = mem_addr_o;
          mem_data_i = mem_m.exists(mem_addr_o) ? mem_m[mem_addr_o] : gen(mem_addr_o);
        end
      end
    end else begin
      cnt = 0;
    end
  end

  task automatic chk(input string nm, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Holds a request until the stall drops; called and returns at posedge+1.
  task automatic access(input logic we, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output int stalls);
    logic done;
    done = 1'b0; stalls = 0; rd = '0;
    cpu_req_i = 1'b1; cpu_we_i = we; cpu_addr_i = a; cpu_data_i = d;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (cpu_stall_o) stalls++;
      else begin done = 1'b1; rd = cpu_data_o; end
      @(posedge clk); #1;
    end
    cpu_req_i = 1'b0; cpu_we_i = 1'b0;
    if (!done) begin
      total++; bad++;
      $display("FAIL access_timeout: addr %h still stalled after 60 cycles, want completion", a);
    end
  endtask

  typedef struct {
    logic req; logic we; logic [31:0] addr; logic [31:0] wdata;
    logic exp_stall; logic exp_swr; logic chk_rd; logic [31:0] exp_rd;
  } vec_t;

  initial begin
    vec_t vt [9];
    logic [LINE_W-1:0] line40, exp_line;
    logic [31:0] rd;
    int st, f0, w0, e0, s0;

    for (int i = 0; i < 8; i++) line40[i*32 +: 32] = 32'h11111111 * 32'(i + 1);
    mem_m[32'h40] = line40;
    vt[0] = '{1'b1, 1'b0, 32'h44, 32'h0, 1'b0, 1'b0, 1'b1, 32'h22222222};
    vt[1] = '{1'b1, 1'b0, 32'h5C, 32'h0, 1'b0, 1'b0, 1'b1, 32'h88888888};
    vt[2] = '{1'b1, 1'b0, 32'h43, 32'h0, 1'b0, 1'b0, 1'b1, 32'h11111111};
    vt[3] = '{1'b1, 1'b1, 32'h48, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 32'h0};
    vt[4] = '{1'b0, 1'b0, 32'h48, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0};
    vt[5] = '{1'b1, 1'b0, 32'h48, 32'h0, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF};
    vt[6] = '{1'b1, 1'b1, 32'h5C, 32'hCAFEF00D, 1'b0, 1'b1, 1'b0, 32'h0};
    vt[7] = '{1'b1, 1'b0, 32'h5C, 32'h0, 1'b0, 1'b0, 1'b1, 32'hCAFEF00D};
    vt[8] = '{1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 1'b0, 1'b1, 32'h11111111};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", 256'(cpu_stall_o), 256'(1'b0));
    chk("rst_mem_en", 256'(mem_enable_o), 256'(1'b0));
    chk("rst_mem_we", 256'(mem_write_o), 256'(1'b0));
    chk("rst_sram_wr", 256'(sram_write_o), 256'(1'b0));
    chk("rst_cpu_data", 256'(cpu_data_o), 256'(32'h0));
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: clean load miss
    access(1'b0, 32'h40, 32'h0, rd, st);
    chk("t1_stalls", 256'(st), 256'(LAT + 2));
    chk("t1_data", 256'(rd), 256'(32'h11111111));
    chk("t1_fill_cnt", 256'(fill_cnt), 256'(1));
    chk("t1_fill_addr", 256'(fill_addr), 256'(32'h40));
    chk("t1_wb_cnt", 256'(wb_cnt), 256'(0));

    // 2/3: hits on the filled line, no memory traffic
    e0 = mem_en_cyc; s0 = sram_wr_cnt;
    for (int i = 0; i < 9; i++) begin
      cpu_req_i = vt[i].req; cpu_we_i = vt[i].we;
      cpu_addr_i = vt[i].addr; cpu_data_i = vt[i].wdata;
      @(negedge clk);
      chk($sformatf("v%0d_stall", i), 256'(cpu_stall_o), 256'(vt[i].exp_stall));
      chk($sformatf("v%0d_swr", i), 256'(sram_write_o), 256'(vt[i].exp_swr));
      if (vt[i].chk_rd) chk($sformatf("v%0d_rd", i), 256'(cpu_data_o), 256'(vt[i].exp_rd));
      @(posedge clk); #1;
    end
    cpu_req_i = 1'b0; cpu_we_i = 1'b0;
    chk("hit_mem_traffic", 256'(mem_en_cyc - e0), 256'(0));
    chk("hit_sram_writes", 256'(sram_wr_cnt - s0), 256'(2));

    // 4: dirty conflict miss -> write-back then fill
    exp_line = line40;
    exp_line[2*32 +: 32] = 32'hDEADBEEF;
    exp_line[7*32 +: 32] = 32'hCAFEF00D;
    access(1'b0, 32'h448, 32'h0, rd, st);
    chk("t4_wb_cnt", 256'(wb_cnt), 256'(1));
    chk("t4_wb_addr", 256'(wb_addr), 256'(32'h40));
    chk("t4_wb_data", wb_data, exp_line);
    chk("t4_gap", 256'(gap), 256'(1));
    chk("t4_fill_addr", 256'(fill_addr), 256'(32'h440));
    chk("t4_data", 256'(rd), 256'(32'h448));
    chk("t4_stalls", 256'(st), 256'(LAT + 1 + LAT + 2));

    // 5: store miss, then evict it to prove it was dirty
    access(1'b1, 32'h80, 32'h12345678, rd, st);
    chk("t5_stalls", 256'(st), 256'(LAT + 2));
    chk("t5_fill_addr", 256'(fill_addr), 256'(32'h80));
    exp_line = gen(32'h80);
    exp_line[31:0] = 32'h12345678;
    chk("t5_sram_line", sram_m[4], exp_line);
    access(1'b0, 32'h1080, 32'h0, rd, st);
    chk("t5_wb_cnt", 256'(wb_cnt), 256'(2));
    chk("t5_wb_addr", 256'(wb_addr), 256'(32'h80));
    chk("t5_wb_data", wb_data, exp_line);
    chk("t5_evict_data", 256'(rd), 256'(32'h1080));

    // 6: reset while waiting on a fill
    f0 = fill_cnt; w0 = wb_cnt;
    cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'hC0;
    @(negedge clk);
    chk("t6_miss_stall", 256'(cpu_stall_o), 256'(1'b1));
    @(posedge clk);
    @(negedge clk); #2;
    rst = 1'b1; #1;
    chk("t6_rst_mem_en", 256'(mem_enable_o), 256'(1'b0));
    chk("t6_rst_stall", 256'(cpu_stall_o), 256'(1'b0));
    cpu_req_i = 1'b0;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("t6_fill_discarded", 256'(fill_cnt), 256'(f0));
    access(1'b0, 32'h40, 32'h0, rd, st);
    chk("t6_reload_stalls", 256'(st), 256'(LAT + 2));
    chk("t6_reload_fill", 256'(fill_cnt), 256'(f0 + 1));
    chk("t6_reload_addr", 256'(fill_addr), 256'(32'h40));
    chk("t6_reload_nowb", 256'(wb_cnt), 256'(w0));
    chk("t6_reload_data", 256'(rd), 256'(32'h11111111));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
